// File: rtl/frame_checker.sv
// Receive-side frame checker: parses 16-bit AXI-stream frames, accumulates payload
// length/checksum and commits results to an 8-bit Avalon-MM register file.
module frame_checker #(
    parameter int unsigned MAX_PAYLOAD_BYTES = 1500
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [7:0]  writedata,
    input  logic        write,
    input  logic        chipselect,
    input  logic [7:0]  address,
    input  logic        read,
    output logic [7:0]  readdata,
    input  logic [15:0] ingress_port_tdata,
    input  logic        ingress_port_tlast,
    output logic        ingress_port_tready,
    input  logic        ingress_port_tvalid
);

    typedef enum logic [1:0] {HEADER, PAYLOAD, DROP} state_t;

    state_t           state_q, state_d;
    logic [2:0]       idx_q, idx_d;
    logic [5:0][7:0]  dst_sh_q, dst_sh_d, src_sh_q, src_sh_d;
    logic [1:0][7:0]  type_sh_q, type_sh_d;
    logic [15:0]      len_acc_q, len_acc_d;
    logic [31:0]      csum_acc_q, csum_acc_d;
    logic [5:0][7:0]  vis_dst_q, vis_dst_d, vis_src_q, vis_src_d, exp_mac_q, exp_mac_d;
    logic [1:0][7:0]  vis_type_q, vis_type_d;
    logic [15:0]      vis_len_q, vis_len_d;
    logic [31:0]      vis_csum_q, vis_csum_d;
    logic [15:0]      frame_cnt_q, frame_cnt_d;
    logic [7:0]       err_cnt_q, err_cnt_d, mm_cnt_q, mm_cnt_d;
    logic [2:0]       status_q, status_d;
    logic [1:0]       ctrl_q, ctrl_d;
    logic             tready_q;
    logic [7:0]       readdata_q, rd_mux;

    logic        xfer, wr, busy;
    logic        done_set, runt_set, ovs_set, err_inc;
    logic [15:0] len_n;
    logic [31:0] csum_n;
    logic [2:0]  src_idx;
    logic [7:0]  rel_addr;

    assign xfer                = ingress_port_tvalid & tready_q;
    assign wr                  = chipselect & write;
    assign busy                = (state_q != HEADER) || (idx_q != 3'd0);
    assign ingress_port_tready = tready_q;
    assign readdata            = readdata_q;

    always_comb begin
        state_d     = state_q;
        idx_d       = idx_q;
        dst_sh_d    = dst_sh_q;
        src_sh_d    = src_sh_q;
        type_sh_d   = type_sh_q;
        len_acc_d   = len_acc_q;
        csum_acc_d  = csum_acc_q;
        vis_dst_d   = vis_dst_q;
        vis_src_d   = vis_src_q;
        vis_type_d  = vis_type_q;
        vis_len_d   = vis_len_q;
        vis_csum_d  = vis_csum_q;
        frame_cnt_d = frame_cnt_q;
        err_cnt_d   = err_cnt_q;
        mm_cnt_d    = mm_cnt_q;
        status_d    = status_q;
        ctrl_d      = ctrl_q;
        exp_mac_d   = exp_mac_q;
        done_set    = 1'b0;
        runt_set    = 1'b0;
        ovs_set     = 1'b0;
        err_inc     = 1'b0;
        len_n       = len_acc_q + 16'd2;
        csum_n      = csum_acc_q + {16'h0000, ingress_port_tdata};
        src_idx     = idx_q - 3'd3;

        if (xfer) begin
            unique case (state_q)
                HEADER: begin
                    if (idx_q < 3'd3) begin
                        dst_sh_d[{idx_q[1:0], 1'b0}] = ingress_port_tdata[15:8];
                        dst_sh_d[{idx_q[1:0], 1'b1}] = ingress_port_tdata[7:0];
                    end else if (idx_q < 3'd6) begin
                        src_sh_d[{src_idx[1:0], 1'b0}] = ingress_port_tdata[15:8];
                        src_sh_d[{src_idx[1:0], 1'b1}] = ingress_port_tdata[7:0];
                    end else begin
                        type_sh_d[0] = ingress_port_tdata[15:8];
                        type_sh_d[1] = ingress_port_tdata[7:0];
                    end
                    if (ingress_port_tlast) begin
                        runt_set = 1'b1;
                        err_inc  = 1'b1;
                        idx_d    = 3'd0;
                    end else if (idx_q == 3'd6) begin
                        state_d    = PAYLOAD;
                        idx_d      = 3'd0;
                        len_acc_d  = '0;
                        csum_acc_d = '0;
                    end else begin
                        idx_d = idx_q + 3'd1;
                    end
                end
                PAYLOAD: begin
                    len_acc_d  = len_n;
                    csum_acc_d = csum_n;
                    if (32'(len_n) > MAX_PAYLOAD_BYTES) begin
                        ovs_set = 1'b1;
                        if (ingress_port_tlast) begin
                            err_inc = 1'b1;
                            state_d = HEADER;
                        end else begin
                            state_d = DROP;
                        end
                    end else if (ingress_port_tlast) begin
                        state_d = HEADER;
                        if (ctrl_q[1] && (dst_sh_d != exp_mac_q)) begin
                            if (mm_cnt_q != 8'hFF) mm_cnt_d = mm_cnt_q + 8'd1;
                        end else begin
                            vis_dst_d   = dst_sh_q;
                            vis_src_d   = src_sh_q;
                            vis_type_d  = type_sh_q;
                            vis_len_d   = len_n;
                            vis_csum_d  = csum_n;
                            frame_cnt_d = frame_cnt_q + 16'd1;
                            done_set    = 1'b1;
                        end
                    end
                end
                DROP: begin
                    if (ingress_port_tlast) begin
                        err_inc = 1'b1;
                        state_d = HEADER;
                    end
                end
                default: state_d = HEADER;
            endcase
        end

        if (err_inc && (err_cnt_q != 8'hFF)) err_cnt_d = err_cnt_q + 8'd1;

        if (wr) begin
            if (address == 8'd23) status_d = '0;
            if (address == 8'd24) ctrl_d = writedata[1:0];
            if (address >= 8'd25 && address <= 8'd30) exp_mac_d[3'(address - 8'd25)] = writedata;
        end
        // Event sets are applied after the clear so a coincident clear loses.
        if (done_set) status_d[0] = 1'b1;
        if (runt_set) status_d[1] = 1'b1;
        if (ovs_set)  status_d[2] = 1'b1;
    end

    always_comb begin
        rd_mux   = '0;
        rel_addr = '0;
        if (address < 8'd6) begin
            rd_mux = vis_dst_q[address[2:0]];
        end else if (address < 8'd12) begin
            rel_addr = address - 8'd6;
            rd_mux   = vis_src_q[rel_addr[2:0]];
        end else if (address >= 8'd25 && address <= 8'd30) begin
            rel_addr = address - 8'd25;
            rd_mux   = exp_mac_q[rel_addr[2:0]];
        end else begin
            unique case (address)
                8'd12:   rd_mux = vis_len_q[7:0];
                8'd13:   rd_mux = vis_len_q[15:8];
                8'd14:   rd_mux = vis_type_q[0];
                8'd15:   rd_mux = vis_type_q[1];
                8'd16:   rd_mux = vis_csum_q[7:0];
                8'd17:   rd_mux = vis_csum_q[15:8];
                8'd18:   rd_mux = vis_csum_q[23:16];
                8'd19:   rd_mux = vis_csum_q[31:24];
                8'd20:   rd_mux = frame_cnt_q[7:0];
                8'd21:   rd_mux = frame_cnt_q[15:8];
                8'd22:   rd_mux = err_cnt_q;
                8'd23:   rd_mux = {4'h0, busy, status_q};
                8'd24:   rd_mux = {6'h00, ctrl_q};
                8'd31:   rd_mux = mm_cnt_q;
                default: rd_mux = '0;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q     <= HEADER;
            idx_q       <= '0;
            dst_sh_q    <= '0;
            src_sh_q    <= '0;
            type_sh_q   <= '0;
            len_acc_q   <= '0;
            csum_acc_q  <= '0;
            vis_dst_q   <= '0;
            vis_src_q   <= '0;
            vis_type_q  <= '0;
            vis_len_q   <= '0;
            vis_csum_q  <= '0;
            frame_cnt_q <= '0;
            err_cnt_q   <= '0;
            mm_cnt_q    <= '0;
            status_q    <= '0;
            ctrl_q      <= 2'b01;
            exp_mac_q   <= '0;
            tready_q    <= 1'b0;
            readdata_q  <= '0;
        end else begin
            state_q     <= state_d;
            idx_q       <= idx_d;
            dst_sh_q    <= dst_sh_d;
            src_sh_q    <= src_sh_d;
            type_sh_q   <= type_sh_d;
            len_acc_q   <= len_acc_d;
            csum_acc_q  <= csum_acc_d;
            vis_dst_q   <= vis_dst_d;
            vis_src_q   <= vis_src_d;
            vis_type_q  <= vis_type_d;
            vis_len_q   <= vis_len_d;
            vis_csum_q  <= vis_csum_d;
            frame_cnt_q <= frame_cnt_d;
            err_cnt_q   <= err_cnt_d;
            mm_cnt_q    <= mm_cnt_d;
            status_q    <= status_d;
            ctrl_q      <= ctrl_d;
            exp_mac_q   <= exp_mac_d;
            tready_q    <= ctrl_d[0];
            if (chipselect && read) readdata_q <= rd_mux;
        end
    end

endmodule

// File: tb/tb_frame_checker.sv
// Directed bench for frame_checker with hand-computed expected register values.
module tb_frame_checker;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic [7:0]  writedata = '0;
    logic        write = 1'b0;
    logic        chipselect = 1'b0;
    logic [7:0]  address = '0;
    logic        read = 1'b0;
    logic [7:0]  readdata;
    logic [15:0] tdata = '0;
    logic        tlast = 1'b0;
    logic        tready;
    logic        tvalid = 1'b0;

    int n_cmp = 0;
    int n_bad = 0;
    logic [15:0] pay [8];
    logic [7:0]  rdv;

    localparam logic [47:0] DST = 48'h021122334455;
    localparam logic [47:0] SRC = 48'h0A0B0C0D0E0F;

    frame_checker #(.MAX_PAYLOAD_BYTES(8)) dut (
        .clk                 (clk),
        .reset               (reset),
        .writedata           (writedata),
        .write               (write),
        .chipselect          (chipselect),
        .address             (address),
        .read                (read),
        .readdata            (readdata),
        .ingress_port_tdata  (tdata),
        .ingress_port_tlast  (tlast),
        .ingress_port_tready (tready),
        .ingress_port_tvalid (tvalid)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
        end
    endtask

    task automatic rd(input logic [7:0] a, output logic [7:0] d);
        @(negedge clk);
        chipselect = 1'b1; read = 1'b1; address = a;
        @(negedge clk);
        d = readdata;
        chipselect = 1'b0; read = 1'b0;
    endtask

    task automatic rd_chk(input string tag, input logic [7:0] a, input logic [7:0] exp);
        logic [7:0] d;
        rd(a, d);
        chk(tag, {24'h0, d}, {24'h0, exp});
    endtask

    task automatic wr(input logic [7:0] a, input logic [7:0] d);
        @(negedge clk);
        chipselect = 1'b1; write = 1'b1; address = a; writedata = d;
        @(negedge clk);
        chipselect = 1'b0; write = 1'b0;
    endtask

    task automatic send_beat(input logic [15:0] d, input logic last);
        int cnt;
        @(negedge clk);
        tdata = d; tlast = last; tvalid = 1'b1;
        cnt = 0;
        while (!tready && cnt < 200) begin
            @(negedge clk);
            cnt++;
        end
        if (cnt >= 200) chk("tready_timeout", 32'(tready), 32'h1);
        @(posedge clk);
        #1 tvalid = 1'b0; tlast = 1'b0;
    endtask

    // runt_at >= 0 ends the frame early on that beat; stall_at >= 0 drops enable before that beat.
    task automatic send_frame(input logic [47:0] dst, input logic [47:0] src, input logic [15:0] typ,
                              input int npay, input int runt_at, input bit gaps, input int stall_at);
        logic [15:0] beats [$];
        int nb;
        beats = '{dst[47:32], dst[31:16], dst[15:0], src[47:32], src[31:16], src[15:0], typ};
        for (int i = 0; i < npay; i++) beats.push_back(pay[i]);
        nb = (runt_at >= 0) ? runt_at + 1 : beats.size();
        for (int i = 0; i < nb; i++) begin
            if (gaps) repeat ($urandom_range(0, 2)) @(negedge clk);
            if (i == stall_at) begin
                wr(8'd24, 8'h00);
                chk("stall_tready", 32'(tready), 32'h0);
                repeat (4) @(negedge clk);
                rd_chk("stall_busy", 8'd23, 8'h08);
                wr(8'd24, 8'h01);
            end
            send_beat(beats[i], i == nb - 1);
        end
    endtask

    task automatic chk_good(input string tag, input logic [15:0] fc);
        rd_chk({tag, "_len0"}, 8'd12, 8'h08);
        rd_chk({tag, "_len1"}, 8'd13, 8'h00);
        rd_chk({tag, "_cs0"},  8'd16, 8'h05);
        rd_chk({tag, "_cs1"},  8'd17, 8'h00);
        rd_chk({tag, "_cs2"},  8'd18, 8'h01);
        rd_chk({tag, "_cs3"},  8'd19, 8'h00);
        rd_chk({tag, "_fc0"},  8'd20, fc[7:0]);
        rd_chk({tag, "_fc1"},  8'd21, fc[15:8]);
    endtask

    initial begin
        pay[0] = 16'h0001; pay[1] = 16'h0002; pay[2] = 16'h0003; pay[3] = 16'hFFFF;
        pay[4] = 16'h0005; pay[5] = 16'h0006; pay[6] = 16'h0007; pay[7] = 16'h0008;

        // Reset
        repeat (3) @(negedge clk);
        chk("rst_tready", 32'(tready), 32'h0);
        chk("rst_readdata", {24'h0, readdata}, 32'h0);
        reset = 1'b1;
        @(negedge clk);
        chk("post_rst_tready", 32'(tready), 32'h1);
        for (int a = 0; a < 32; a++) rd_chk("rst_reg", 8'(a), (a == 24) ? 8'h01 : 8'h00);
        rd_chk("unmapped", 8'd40, 8'h00);

        // Good frame
        send_frame(DST, SRC, 16'h0800, 4, -1, 1'b0, -1);
        chk_good("good", 16'd1);
        rd_chk("good_status", 8'd23, 8'h01);
        rd_chk("good_dst0", 8'd0, 8'h02);
        rd_chk("good_dst5", 8'd5, 8'h55);
        rd_chk("good_src0", 8'd6, 8'h0A);
        rd_chk("good_src5", 8'd11, 8'h0F);
        rd_chk("good_type0", 8'd14, 8'h08);
        rd_chk("good_type1", 8'd15, 8'h00);
        repeat (2) @(negedge clk);
        chk("rd_hold", {24'h0, readdata}, 32'h00);
        wr(8'd20, 8'hFF);
        rd_chk("ro_write", 8'd20, 8'h01);

        // Stalls: random gaps and enable off mid-payload
        wr(8'd23, 8'h00);
        send_frame(DST, SRC, 16'h0800, 4, -1, 1'b1, 9);
        chk_good("stall", 16'd2);

        // Runt
        wr(8'd23, 8'h00);
        send_frame(48'hAABBCCDDEEFF, SRC, 16'h0800, 4, 4, 1'b0, -1);
        rd_chk("runt_err", 8'd22, 8'h01);
        rd_chk("runt_status", 8'd23, 8'h02);
        rd_chk("runt_dst0", 8'd0, 8'h02);
        rd_chk("runt_fc", 8'd20, 8'h02);
        send_frame(DST, SRC, 16'h0800, 4, -1, 1'b0, -1);
        rd_chk("after_runt_fc", 8'd20, 8'h03);
        rd_chk("after_runt_status", 8'd23, 8'h03);

        // Oversize: 5 beats (tlast on offending beat), then 6 beats (through DROP)
        wr(8'd23, 8'h00);
        pay[3] = 16'h0004;
        send_frame(DST, SRC, 16'h0800, 5, -1, 1'b0, -1);
        rd_chk("ovs_err", 8'd22, 8'h02);
        rd_chk("ovs_status", 8'd23, 8'h04);
        rd_chk("ovs_fc", 8'd20, 8'h03);
        rd_chk("ovs_len", 8'd12, 8'h08);
        rd_chk("ovs_cs2", 8'd18, 8'h01);
        send_frame(DST, SRC, 16'h0800, 6, -1, 1'b0, -1);
        rd_chk("drop_err", 8'd22, 8'h03);
        pay[3] = 16'hFFFF;
        send_frame(DST, SRC, 16'h0800, 4, -1, 1'b0, -1);
        chk_good("after_ovs", 16'd4);
        rd_chk("after_ovs_status", 8'd23, 8'h05);

        // Filter
        wr(8'd23, 8'h00);
        wr(8'd25, 8'h02); wr(8'd26, 8'h11); wr(8'd27, 8'h22);
        wr(8'd28, 8'h33); wr(8'd29, 8'h44); wr(8'd30, 8'h56);
        wr(8'd24, 8'h03);
        rd_chk("ctrl_rb", 8'd24, 8'h03);
        send_frame(DST, SRC, 16'h0800, 4, -1, 1'b0, -1);
        rd_chk("flt_mm", 8'd31, 8'h01);
        rd_chk("flt_fc", 8'd20, 8'h04);
        rd_chk("flt_status", 8'd23, 8'h00);
        wr(8'd30, 8'h55);
        send_frame(DST, SRC, 16'h0800, 4, -1, 1'b0, -1);
        rd_chk("flt_match_fc", 8'd20, 8'h05);
        rd_chk("flt_match_mm", 8'd31, 8'h01);

        // Reset mid-frame discards the partial frame without counting an error
        send_frame(DST, SRC, 16'h0800, 4, 2, 1'b0, -1);
        send_beat(16'h0211, 1'b0);
        send_beat(16'h2233, 1'b0);
        @(negedge clk);
        reset = 1'b0;
        repeat (2) @(negedge clk);
        reset = 1'b1;
        send_frame(DST, SRC, 16'h0800, 4, -1, 1'b0, -1);
        chk_good("mid_rst", 16'd1);
        rd_chk("mid_rst_err", 8'd22, 8'h00);
        rd_chk("mid_rst_status", 8'd23, 8'h01);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/frame_checker.md
# frame_checker

Receive-side counterpart of the frame generator. Consumes 16-bit AXI-stream Ethernet-style frames on its ingress port and parses the header. Accumulates a payload length and a 32-bit payload checksum, then commits results to an 8-bit Avalon-MM register file at end of frame. It sits at the egress of the filter datapath, so the bench and software can compare generator checksum/length registers against the checker's.

## Interface
- `MAX_PAYLOAD_BYTES`, default 1500: largest payload accepted; larger frames are dropped as oversize.
- `clk` in 1: single clock; all logic on posedge.
- `reset` in 1: synchronous, active-low (0 = reset).
- `writedata` in 8: Avalon write data.
- `write` in 1: Avalon write strobe.
- `chipselect` in 1: Avalon select; read/write ignored when 0.
- `address` in 8: register byte address.
- `read` in 1: Avalon read strobe.
- `readdata` out 8: registered read data.
- `ingress_port_tdata` in 16: beat; [15:8] is the first wire byte, [7:0] the second.
- `ingress_port_tlast` in 1: last beat of frame.
- `ingress_port_tready` out 1: checker can accept a beat.
- `ingress_port_tvalid` in 1: beat valid.

## Operation
- Frame layout in beats:
  - Beats 0-2: destination MAC, bytes 0..5.
  - Beats 3-5: source MAC.
  - Beat 6: type, [15:8] = type byte 0.
  - Beats 7..N: payload. Payload length = 2 × payload beats (payloads are always even).
- Checksum: 32-bit sum of payload beats, each zero-extended tdata, modulo 2^32.
- FSM states:
  - HEADER (reset state): beat index 0-6.
  - PAYLOAD.
  - DROP.
- Transfers: a beat transfers when tvalid & tready. Only transfers advance the index, accumulators or state.
- HEADER:
  - Capture header bytes into shadow registers.
  - tlast on any beat 0-6 → runt error, return to HEADER index 0.
  - Otherwise go to PAYLOAD after beat 6.
- PAYLOAD:
  - Add each beat to the checksum accumulator and add 2 to the length accumulator.
  - If the length would exceed MAX_PAYLOAD_BYTES → oversize error latched, go to DROP (or finish directly if that beat has tlast).
  - tlast on a good frame → commit, return to HEADER.
- DROP: consume beats until tlast, count the error, return to HEADER.
- Commit (on the tlast edge) copies shadow header, length and checksum into the visible registers. It also increments the frame count (16-bit, wraps 0xFFFF→0) and sets status.done.
- Filter mode (control bit1 = 1): a frame whose destination MAC ≠ the expected MAC is not committed. It increments the mismatch count (8-bit, saturating) instead.
- Errored frames never commit. They increment the error count (8-bit, saturating at 0xFF) and set the matching status bit (runt or oversize). The visible header, length and checksum registers keep their prior values.
- Register map (R = read-only; writes to R addresses are ignored):
  - 0-5 R: destination MAC bytes 0-5.
  - 6-11 R: source MAC.
  - 12-13 R: payload length, low byte first.
  - 14-15 R: type bytes 0-1.
  - 16-19 R: checksum, LSB at 16.
  - 20-21 R: frame count, low byte first.
  - 22 R: error count.
  - 23 RW status, all sticky:
    - bit0 done, bit1 runt, bit2 oversize.
    - bit3 busy (live: FSM not at HEADER index 0).
    - Any write clears bits 0-2.
  - 24 RW control: bit0 enable (reset 1), bit1 filter (reset 0).
  - 25-30 RW: expected destination MAC bytes 0-5 (reset 0).
  - 31 R: mismatch count.
  - Unmapped addresses read 0.

## Timing
- Reset values:
  - Outputs: readdata 0 and tready 0 while reset is low.
  - Registers: all counters and captured registers 0; control 0x01.
- tready = enable, registered. It goes high on the first cycle after reset deasserts.
- Clearing enable mid-frame stalls the frame. FSM state, shadow registers and accumulators are held, and the frame resumes when enable returns to 1.
- Read latency is one cycle: readdata is valid on the cycle after `chipselect & read`. readdata holds its value when not reading.
- Commit results are visible to a read issued on the cycle after the tlast transfer.
- Simultaneous events:
  - Status-clear write in the same cycle as a commit or error: the set wins for that event's bit.
  - Control write in the same cycle as a beat transfer: that beat still transfers; the new tready applies from the next cycle.
- Reset mid-frame: discard the partial frame, with no error counted. The next transferred beat is beat 0.

## Test plan
- Reset:
  - Stimulus: hold reset low for 3 cycles, then read 0-31.
  - Required: tready = 0 during reset and 1 after; all reads 0 except control = 0x01.
- Good frame:
  - Stimulus: dst 02:11:22:33:44:55, src 0A:0B:0C:0D:0E:0F, type 0x0800, payload 0x0001, 0x0002, 0x0003, 0xFFFF.
  - Required: length 0x0008, checksum 0x00010005, frame count 1, status = 0x01, reg 0 = 0x02.
- Stalls:
  - Stimulus: the good frame again with random tvalid gaps and enable toggled off for 5 cycles mid-payload.
  - Required: identical length and checksum; frame count 2.
- Runt:
  - Stimulus: tlast on beat 4.
  - Required: error count 1, status bit1 set, frame count and captured registers unchanged. The following good frame commits normally.
- Oversize (MAX_PAYLOAD_BYTES = 8):
  - Stimulus: 5 payload beats.
  - Required: dropped, status bit2 set, error count +1, no commit. The next 4-beat frame commits.
- Filter:
  - Stimulus: expected MAC 02:11:22:33:44:56, control = 0x03, send the good frame.
  - Required: mismatch count 1, frame count unchanged.
  - Then set expected byte 5 = 0x55 and resend: frame count +1.
